// File: rtl/seq_launcher_pkg.sv
// Shared constants for the seq_launcher block: one-hot state encoding, state
// indices, LED bit positions and the downstream sequencer's FINISH hold length.
package seq_launcher_pkg;

  localparam int unsigned NumStates = 7;

  localparam int unsigned IdxIdle        = 0;
  localparam int unsigned IdxWaitIdle    = 1;
  localparam int unsigned IdxStart       = 2;
  localparam int unsigned IdxWaitFinish  = 3;
  localparam int unsigned IdxWaitRelease = 4;
  localparam int unsigned IdxDone        = 5;
  localparam int unsigned IdxError       = 6;

  typedef enum logic [NumStates-1:0] {
    StIdle        = 7'(1 << IdxIdle),
    StWaitIdle    = 7'(1 << IdxWaitIdle),
    StStart       = 7'(1 << IdxStart),
    StWaitFinish  = 7'(1 << IdxWaitFinish),
    StWaitRelease = 7'(1 << IdxWaitRelease),
    StDone        = 7'(1 << IdxDone),
    StError       = 7'(1 << IdxError)
  } state_e;

  // Bit positions in the 8-bit status display; bits 3:0 carry runs_done[3:0].
  localparam int unsigned LedError = 7;
  localparam int unsigned LedDone  = 6;
  localparam int unsigned LedBusy  = 5;
  localparam int unsigned LedStart = 4;

  // Watchdog counter width; covers TIMEOUT up to 2^16.
  localparam int unsigned WdogW = 16;

  // Cycles the standard sequencer holds FINISH high.
  localparam int unsigned FinishHold = 16;

  // States in which the launcher is waiting on the sequencer.
  function automatic logic is_waiting(state_e s);
    return (s == StWaitIdle) || (s == StStart) || (s == StWaitFinish) || (s == StWaitRelease);
  endfunction

endpackage

// File: rtl/seq_wdog.sv
// Watchdog counter for seq_launcher: clears on request, counts while enabled,
// flags expiry when the count reaches TIMEOUT-1.
module seq_wdog
  import seq_launcher_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WdogW-1:0] cnt_q, cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + WdogW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == WdogW'(TIMEOUT - 1));

endmodule

// File: rtl/seq_launcher.sv
// Batch initiator for the start/idle/finish sequencer handshake.
// Optional watchdog + ERROR state built when SEQ_LAUNCHER_WDOG_EN is defined.
module seq_launcher
  import seq_launcher_pkg::*;
#(
  parameter int unsigned RUNS_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic [RUNS_W-1:0] num_runs,
  input  logic              abort,
  input  logic              slave_idle,
  input  logic              slave_finish,
  output logic              slave_start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [RUNS_W-1:0] runs_done,
  output logic [7:0]        leds
);

  if (TIMEOUT < 2 || TIMEOUT > 65536 || RUNS_W < 4) begin : g_param_check
    $error("seq_launcher: TIMEOUT must be 2..65536 and RUNS_W at least 4");
  end

  state_e            state_q, state_d;
  logic [RUNS_W-1:0] target_q, target_d;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout;

`ifdef SEQ_LAUNCHER_WDOG_EN
  logic error_q, error_d;
  logic wdog_clear;
  logic wdog_enable;

  assign wdog_clear  = (state_d != state_q);
  assign wdog_enable = is_waiting(state_q);

  seq_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (wdog_clear),
    .enable (wdog_enable),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state and batch bookkeeping; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    runs_d   = runs_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          target_d = num_runs;
          runs_d   = '0;
          state_d  = (num_runs == '0) ? StDone : StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (slave_idle)   state_d = StStart;
        else if (timeout) state_d = StError;
      end
      StStart: begin
        if (!slave_idle)  state_d = StWaitFinish;
        else if (timeout) state_d = StError;
      end
      StWaitFinish: begin
        if (slave_finish) state_d = StWaitRelease;
        else if (timeout) state_d = StError;
      end
      StWaitRelease: begin
        if (slave_idle && !slave_finish) begin
          runs_d  = runs_q + RUNS_W'(1);
          state_d = (runs_d == target_q) ? StDone : StStart;
        end else if (timeout) begin
          state_d = StError;
        end
      end
      StDone:  state_d = StIdle;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d  = StIdle;
      target_d = target_q;
      runs_d   = runs_q;
    end
  end

  // Registered outputs follow the current state; abort forces them low at once.
  // slave_start also drops as soon as the sequencer is seen leaving idle.
  always_comb begin
    start_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (!abort) begin
      start_d = (state_q == StStart) && slave_idle;
      busy_d  = is_waiting(state_q);
      done_d  = (state_q == StDone);
    end
  end

  // State, batch and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      target_q <= '0;
      runs_q   <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      runs_q   <= runs_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef SEQ_LAUNCHER_WDOG_EN
  // Error follows the ERROR state; cleared by abort.
  always_comb begin
    error_d = (state_q == StError) && !abort;
  end

  // Error register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign slave_start = start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign runs_done   = runs_q;

  // Status display assembled from registered signals.
  always_comb begin
    leds           = '0;
    leds[LedError] = error;
    leds[LedDone]  = done_q;
    leds[LedBusy]  = busy_q;
    leds[LedStart] = start_q;
    leds[3:0]      = runs_q[3:0];
  end

endmodule

// File: tb/tb_seq_launcher.sv
// Scoreboard bench for seq_launcher with a behavioural sequencer slave.
module tb_seq_launcher;
  import seq_launcher_pkg::*;

  localparam int unsigned RunsW = 8;
  // Slave: 3 busy cycles, then FINISH for FinishHold cycles -> 22 cycles per run.
  localparam int RunPeriod = 3 + 3 + int'(FinishHold);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             go = 1'b0;
  logic [RunsW-1:0] num_runs = '0;
  logic             abort = 1'b0;
  logic             slave_idle = 1'b1;
  logic             slave_finish = 1'b0;
  logic             slave_start, busy, done, error;
  logic [RunsW-1:0] runs_done;
  logic [7:0]       leds;

  always #5 clk = ~clk;

  seq_launcher #(
    .RUNS_W (RunsW),
    .TIMEOUT(64)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .go          (go),
    .num_runs    (num_runs),
    .abort       (abort),
    .slave_idle  (slave_idle),
    .slave_finish(slave_finish),
    .slave_start (slave_start),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .runs_done   (runs_done),
    .leds        (leds)
  );

  // Standard sequencer model.
  bit sw_0 = 1'b1;
  int s_phase = 0;
  int s_cnt = 0;
  always @(posedge clk) begin
    case (s_phase)
      0: if (slave_start) begin
        s_phase    <= 1;
        s_cnt      <= 0;
        slave_idle <= 1'b0;
      end
      1: begin
        s_cnt <= s_cnt + 1;
        if (s_cnt >= 2 && sw_0) begin
          s_phase      <= 2;
          s_cnt        <= 0;
          slave_finish <= 1'b1;
        end
      end
      default: begin
        s_cnt <= s_cnt + 1;
        if (s_cnt == int'(FinishHold) - 1) begin
          s_phase      <= 0;
          slave_finish <= 1'b0;
          slave_idle   <= 1'b1;
        end
      end
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int n;
    int lat;
    int c0;
    int rises0;
  } exp_t;
  exp_t sb_q[$];

  int nchecks = 0;
  int nerrors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Monitor: counts start windows, checks run stepping, pops on each done pulse.
  int rises = 0;
  logic start_prev = 1'b0;
  logic [RunsW-1:0] runs_prev = '0;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (slave_start && !start_prev) rises++;
      if (runs_done != runs_prev && runs_done != '0)
        check("runs_step", 32'(runs_done), 32'(runs_prev) + 1);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("done_latency", cyc - e.c0, e.lat);
          check("runs_done", 32'(runs_done), e.n);
          check("start_windows", rises - e.rises0, e.n);
          check("busy_at_done", 32'(busy), 32'd0);
          check("error_at_done", 32'(error), 32'd0);
          check("leds_at_done", 32'(leds), 32'h40 | (e.n & 32'hf));
        end
      end
    end
    start_prev = slave_start;
    runs_prev  = runs_done;
  end

  task automatic wait_slave_idle();
    int i;
    for (i = 0; i < 200 && s_phase != 0; i++) @(posedge clk);
    if (s_phase != 0) check("slave_idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue go; leaves time just after the edge that sampled it.
  task automatic issue_go(input int n, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    go       = 1'b1;
    num_runs = RunsW'(n);
    @(posedge clk);
    #1;
    go = 1'b0;
    if (push) begin
      e.n      = n;
      e.lat    = (n == 0) ? 1 : RunPeriod * n + 2;
      e.c0     = cyc;
      e.rises0 = rises;
      sb_q.push_back(e);
    end
  endtask

  task automatic run_batch(input int n);
    int i;
    wait_slave_idle();
    issue_go(n, 1'b1);
    for (i = 0; i < RunPeriod * n + 40 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      check("done_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(slave_start), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_runs"}, 32'(runs_done), 32'd0);
    check({tag, "_leds"}, 32'(leds), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Directed batches.
    run_batch(1);
    run_batch(3);
    run_batch(0);

    // Randomized batches with random gaps.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_batch(int'($urandom_range(0, 3)));
    end

    // Abort during run 2 of 4: no done pulse, runs_done held at 1.
    wait_slave_idle();
    issue_go(4, 1'b0);
    for (i = 0; i < 200 && !(runs_done == 8'd1 && slave_start); i++) @(negedge clk);
    check("abort_reach_run2", 32'(runs_done == 8'd1 && slave_start), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_start", 32'(slave_start), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_runs", 32'(runs_done), 32'd1);
    check("abort_done", 32'(done), 32'd0);

    // go together with abort in IDLE: stays idle, runs_done untouched.
    @(negedge clk);
    go       = 1'b1;
    abort    = 1'b1;
    num_runs = '0;
    @(posedge clk);
    #1;
    go    = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("goabort_busy", 32'(busy), 32'd0);
    check("goabort_runs", 32'(runs_done), 32'd1);
    check("goabort_start", 32'(slave_start), 32'd0);
    repeat (30) @(posedge clk);

`ifdef SEQ_LAUNCHER_WDOG_EN
    // Hung sequencer: watchdog fires after 64 cycles in WAIT_FINISH.
    wait_slave_idle();
    sw_0 = 1'b0;
    issue_go(1, 1'b0);
    repeat (68) @(posedge clk);
    #1;
    check("wdog_early", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    check("wdog_error", 32'(error), 32'd1);
    check("wdog_start", 32'(slave_start), 32'd0);
    check("wdog_led7", 32'(leds[7]), 32'd1);
    check("wdog_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("wdog_sticky", 32'(error), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("wdog_abort_error", 32'(error), 32'd0);
    check("wdog_abort_busy", 32'(busy), 32'd0);
    sw_0 = 1'b1;
    run_batch(2);
`endif

    // Asynchronous reset mid-WAIT_RELEASE, then a normal batch.
    wait_slave_idle();
    issue_go(2, 1'b1);
    for (i = 0; i < 100 && !slave_finish; i++) @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_batch(1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/seq_launcher.md
# seq_launcher

Initiator for the start/idle/finish sequencer handshake. Takes a batch request (`go` plus a run count) and drives `slave_start` into a downstream sequencer. For each run it waits until the sequencer leaves idle, raises finish, and returns to idle, and it counts completed runs. It reports done, busy and error to the host, and an optional watchdog aborts a hung sequencer.

## Interface
- `RUNS_W`, default 8: width of the run count and the completed-run counter.
- `TIMEOUT`, default 64: maximum cycles allowed in any waiting state. Legal range is 2..2^16.
- `clk` in, 1: single clock, rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `go` in, 1: batch request, sampled in IDLE only.
- `num_runs` in, RUNS_W: number of runs, latched when `go` is accepted.
- `abort` in, 1: synchronous abort, effective in every state.
- `slave_idle` in, 1: sequencer idle flag.
- `slave_finish` in, 1: sequencer finish flag.
- `slave_start` out, 1: start request to the sequencer.
- `busy` out, 1: high in every state except IDLE, DONE and ERROR.
- `done` out, 1: one-cycle pulse when the batch completes.
- `error` out, 1: sticky watchdog error.
- `runs_done` out, RUNS_W: count of completed runs.
- `leds` out, 8: status display.

## Operation
- States: IDLE, WAIT_IDLE, START, WAIT_FINISH, WAIT_RELEASE, DONE, ERROR. The encoding is one-hot.
- IDLE:
  - `go`=1: latch `num_runs` into `target`, clear `runs_done`.
  - If `num_runs`==0, go to DONE; otherwise go to WAIT_IDLE.
- WAIT_IDLE: `slave_idle`=1 → START.
- START:
  - `slave_start`=1.
  - `slave_idle`=0 (the sequencer has accepted the request) → WAIT_FINISH.
- WAIT_FINISH: `slave_finish`=1 → WAIT_RELEASE.
- WAIT_RELEASE:
  - Wait for `slave_idle`=1 and `slave_finish`=0.
  - On that condition, `runs_done`++.
  - If the new count equals `target`, go to DONE; otherwise go directly to START.
- DONE: `done`=1 for one cycle, then IDLE.
- ERROR:
  - `error`=1 and `slave_start`=0.
  - Held until `abort`=1, which returns to IDLE. `go` is ignored in ERROR.
- `abort`=1 in any state:
  - Next state is IDLE; `slave_start` drops on the next edge.
  - `runs_done` keeps its value; `error` clears.
  - `abort` has priority over every other transition.
- `runs_done` wraps modulo 2^RUNS_W. It cannot overflow, because it is bounded by `target`.
- `leds` = {`error`, `done`, `busy`, `slave_start`, `runs_done[3:0]`}, combinational from registers.

## Timing
- Reset values: state=IDLE, and `slave_start`, `busy`, `done`, `error`, `runs_done`, `leds` all 0. Reset is asynchronous and may arrive mid-run.
- All outputs except `leds` are registered from state.
- `slave_start` rises 2 cycles after `go` is sampled, provided `slave_idle`=1 throughout.
- `slave_start` is held until `slave_idle` is seen low; it falls the cycle after that.
- Back-to-back runs: `slave_start` is reasserted the cycle after WAIT_RELEASE sees the release condition.
- `num_runs`=0: the `done` pulse occurs the cycle after `go` is sampled, and `slave_start` never asserts.
- Watchdog counter:
  - Cleared on every state transition.
  - Increments in WAIT_IDLE, START, WAIT_FINISH and WAIT_RELEASE.
  - If it reaches TIMEOUT-1 and the exit condition is still false at that edge, the next state is ERROR.
  - If the exit condition and the timeout occur on the same edge, the exit wins.
- `abort` and `go` asserted together in IDLE: the block stays in IDLE.

## Configuration
- `SEQ_LAUNCHER_WDOG_EN` defined: the watchdog counter and the ERROR state are built.
- Not defined:
  - No counter logic and no TIMEOUT checks.
  - `error` is tied to 0.
  - Waiting states wait indefinitely; `abort` is the only escape.

## Structure
- Shared package `seq_launcher_pkg`:
  - State localparams (one-hot, 7 bits).
  - State-index constants.
  - LED bit-position constants.
  - The sequencer's FINISH hold length, 16 cycles, for benches.
- One sub-module, `seq_wdog`: a loadable up-counter with `clear`, `enable` and `expired` (compare to TIMEOUT-1). It is instantiated only under `SEQ_LAUNCHER_WDOG_EN`.

## Test plan
All scenarios use the standard sequencer as the bench slave, with `sw_0`=1 unless stated otherwise.
- `go`, `num_runs`=1, default params → `slave_start` high for 2 cycles; `done` pulse 24 cycles after `go` is sampled; `runs_done`=1; `busy` low afterwards.
- `num_runs`=3 → exactly 3 `slave_start` assertion windows; `runs_done` steps 1, 2, 3; a single `done` pulse; `error`=0.
- `num_runs`=0 → `done` the cycle after `go`; `slave_start` never high; `runs_done`=0.
- With WDOG_EN, `TIMEOUT`=64, `sw_0`=0 → WAIT_FINISH is never satisfied; `error`=1 after 64 cycles in WAIT_FINISH; `slave_start`=0; `leds[7]`=1. `abort` then gives IDLE with `error`=0.
- `abort` pulse during run 2 of 4 → IDLE next cycle; `slave_start`=0; `runs_done`=1; no `done` pulse.
- `reset_n` low mid-WAIT_RELEASE, between clock edges → outputs go to 0 immediately; after release, a new `go` with `num_runs`=1 completes normally.
